vector_list_sequencer: RTL and testbench
========================================

VECTOR_LIST_SEQUENCER -- requirements
Module: vector_list_sequencer

Interface
REQ-001 SHALL have parameter COORD_W, default 12: width of X/Y beam coordinates.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (power of 2): number of command entries buffered.
REQ-003 SHALL have parameter JUMP_SETTLE, default 8: idle cycles inserted after each JUMP completes.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 4: cycles to wait for ready to fall after issuing a command.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port enable  input  1  high = consume commands; low = stop after the current command.
REQ-008 SHALL have port cmd_valid  input  1  host command strobe.
REQ-009 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-010 SHALL have port cmd_op  input  2  opcode: 00 NOP, 01 JUMP, 10 DRAW, 11 END_FRAME.
REQ-011 SHALL have port cmd_x  input  COORD_W  target X.
REQ-012 SHALL have port cmd_y  input  COORD_W  target Y.
REQ-013 SHALL have port x  output  COORD_W  coordinate presented to the line drawer.
REQ-014 SHALL have port y  output  COORD_W  coordinate presented to the line drawer.
REQ-015 SHALL have port draw  output  1  one-cycle pulse: draw a line to (x,y).
REQ-016 SHALL have port jump  output  1  one-cycle pulse: blanked move to (x,y).
REQ-017 SHALL have port ready  input  1  line drawer idle (high) or busy (low).
REQ-018 SHALL have port busy  output  1  a command is in flight or settling.
REQ-019 SHALL have port frame_done  output  1  one-cycle pulse when END_FRAME retires.
REQ-020 SHALL have port frame_count  output  16  count of retired END_FRAME commands.

Function
REQ-021 SHALL push {op,x,y} into the FIFO on a clock edge where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal not-full.
REQ-022 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged, and a push while full is ignored.
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, SETTLE, FRAME.
REQ-024 In IDLE the FSM SHALL pop the FIFO head when enable=1, the FIFO is non-empty and ready=1, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-025 On a NOP pop the FSM SHALL return to IDLE with no output pulse.
REQ-026 On an END_FRAME pop the FSM SHALL go to FRAME, pulse frame_done for 1 cycle, increment frame_count (wrapping 0xFFFF->0), then return to IDLE.
REQ-027 In ISSUE, x/y SHALL be registered from the entry and draw or jump pulsed high for exactly 1 cycle in the same cycle; the FSM then goes to WAIT_ACK.
REQ-028 x/y SHALL hold their last issued values until the next JUMP/DRAW issues.
REQ-029 WAIT_ACK SHALL go to WAIT_DONE when ready=0, or to the completion step after ACK_TIMEOUT cycles with ready=1 (zero-length move).
REQ-030 WAIT_DONE SHALL go to the completion step on the first cycle with ready=1.
REQ-031 Completion of a JUMP SHALL enter SETTLE for exactly JUMP_SETTLE cycles, then IDLE; completion of a DRAW SHALL go directly to IDLE.
REQ-032 draw and jump SHALL never be high simultaneously, and no new command SHALL issue before the previous one completes.
REQ-033 Deasserting enable SHALL NOT abort an in-flight command; it SHALL only block the next pop in IDLE.
REQ-034 busy SHALL be 1 in every state except IDLE.

Reset
REQ-035 While reset=0 at a clock edge, the block SHALL set FSM=IDLE, flush the FIFO, and set x=0, y=0, draw=0, jump=0, busy=0, frame_done=0, frame_count=0; cmd_ready SHALL be 1 on the first cycle after release.
REQ-036 A reset during WAIT_ACK, WAIT_DONE or SETTLE SHALL discard the in-flight command without issuing another pulse.

Structure
REQ-037 A shared package vector_pkg SHALL hold the opcode enum, the command struct and the COORD_W default.
REQ-038 The FIFO SHALL be the sub-module vector_cmd_fifo, synchronous with registered full/empty flags.

Verification
REQ-039 The bench SHALL cover: push JUMP(10,15) then DRAW(20,30) with a drawer model (ready low for 5 cycles) -> jump pulse with x=10,y=15; draw pulse with x=20,y=30 exactly 8 settle cycles after ready returns.
REQ-040 The bench SHALL cover: push 17 commands with enable=0 -> cmd_ready=0 after 16, the 17th is dropped, no pulses; raising enable -> 16 commands issue in order.
REQ-041 The bench SHALL cover: END_FRAME with frame_count preloaded to 0xFFFF via repeated frames -> frame_done pulse, frame_count=0x0000.
REQ-042 The bench SHALL cover: DRAW with ready held at 1 -> draw pulse, then IDLE after 4 timeout cycles, then the next command issues.
REQ-043 The bench SHALL cover: reset=0 asserted in WAIT_DONE -> next cycle x=y=0, busy=0, FIFO empty, no further pulses.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types for the vector list sequencer: opcodes, command record, FSM states.
package vector_pkg;

  localparam int unsigned COORD_W = 12;

  typedef enum logic [1:0] {
    OpNop      = 2'b00,
    OpJump     = 2'b01,
    OpDraw     = 2'b10,
    OpEndFrame = 2'b11
  } op_e;

  typedef struct packed {
    op_e                op;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vector_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StSettle,
    StFrame
  } state_e;

endpackage

// File: rtl/vector_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags; push while full is dropped.
module vector_cmd_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/vector_list_sequencer.sv
// Pops buffered JUMP/DRAW/END_FRAME commands and hands them to a line drawer one at a time.
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int unsigned COORD_W     = vector_pkg::COORD_W,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned JUMP_SETTLE = 8,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               draw,
  output logic               jump,
  input  logic               ready,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int unsigned EntryW     = 2 + 2 * COORD_W;
  localparam logic [15:0] AckLast    = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;
  localparam logic [15:0] SettleLast = (JUMP_SETTLE > 0) ? 16'(JUMP_SETTLE - 1) : 16'd0;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;
  op_e               head_op;
  logic [COORD_W-1:0] head_x, head_y;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               is_jump_q, is_jump_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               draw_q, draw_d, jump_q, jump_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               complete;

  assign fifo_wdata = {cmd_op, cmd_x, cmd_y};
  assign head_op    = op_e'(fifo_rdata[EntryW-1 -: 2]);
  assign head_x     = fifo_rdata[2*COORD_W-1 -: COORD_W];
  assign head_y     = fifo_rdata[COORD_W-1:0];

  vector_cmd_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_jump_d     = is_jump_q;
    x_d           = x_q;
    y_d           = y_q;
    draw_d        = 1'b0;
    jump_d        = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    fifo_pop      = 1'b0;
    complete      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && !fifo_empty && ready) begin
          fifo_pop = 1'b1;
          // Pulses are registered here so they appear during the ISSUE/FRAME cycle.
          case (head_op)
            OpNop: state_d = StIdle;
            OpEndFrame: begin
              state_d       = StFrame;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end
            default: begin
              state_d   = StIssue;
              x_d       = head_x;
              y_d       = head_y;
              is_jump_d = (head_op == OpJump);
              jump_d    = (head_op == OpJump);
              draw_d    = (head_op == OpDraw);
            end
          endcase
        end
      end
      StIssue: begin
        state_d = StWaitAck;
        cnt_d   = '0;
      end
      StWaitAck: begin
        if (!ready) begin
          state_d = StWaitDone;
        end else if (cnt_q >= AckLast) begin
          complete = 1'b1;  // drawer never went busy: zero-length move
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitDone: begin
        if (ready) complete = 1'b1;
      end
      StSettle: begin
        if (cnt_q >= SettleLast) state_d = StIdle;
        else                     cnt_d   = cnt_q + 16'd1;
      end
      StFrame: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (complete) begin
      if (is_jump_q && (JUMP_SETTLE != 0)) begin
        state_d = StSettle;
        cnt_d   = '0;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      is_jump_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      draw_q        <= 1'b0;
      jump_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_jump_q     <= is_jump_d;
      x_q           <= x_d;
      y_q           <= y_d;
      draw_q        <= draw_d;
      jump_q        <= jump_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign cmd_ready   = !fifo_full;
  assign x           = x_q;
  assign y           = y_q;
  assign draw        = draw_q;
  assign jump        = jump_q;
  assign busy        = (state_q != StIdle);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Directed bench for vector_list_sequencer: vector tables plus hand-timed drawer sequences.
module tb_vector_list_sequencer;

  localparam logic [1:0] OP_NOP = 2'b00, OP_JUMP = 2'b01, OP_DRAW = 2'b10, OP_END = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [11:0] cmd_x = '0, cmd_y = '0;
  logic [11:0] x, y;
  logic        draw, jump;
  logic        ready = 1'b1;
  logic        busy, frame_done;
  logic [15:0] frame_count;

  vector_list_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .x           (x),
    .y           (y),
    .draw        (draw),
    .jump        (jump),
    .ready       (ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;
  int cyc = 0, fd_count = 0, overlap = 0;
  int drawer_on = 0, low_len = 5, left = 0, rise_cyc = 0;
  logic [1:0]  p_kind[$];
  logic [11:0] p_x[$], p_y[$];
  int          p_cyc[$];

  // Pulse log plus a line-drawer model that drops ready for low_len cycles per command.
  always @(negedge clk) begin
    cyc++;
    if (jump && draw) overlap++;
    if (frame_done) fd_count++;
    if (jump || draw) begin
      p_kind.push_back(jump ? OP_JUMP : OP_DRAW);
      p_x.push_back(x);
      p_y.push_back(y);
      p_cyc.push_back(cyc);
    end
    if (drawer_on != 0) begin
      if (jump || draw) begin
        ready = 1'b0;
        left  = low_len;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          ready    = 1'b1;
          rise_cyc = cyc;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [11:0] px, input logic [11:0] py,
                      output logic rdy);
    @(negedge clk);
    #1;
    rdy       = cmd_ready;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = px;
    cmd_y     = py;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (p_kind.size() >= n) break;
      @(negedge clk);
      #1;
    end
    check(name, p_kind.size(), n);
  endtask

  task automatic drawer_off();
    drawer_on = 0;
    left      = 0;
    ready     = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] x;
    logic [11:0] y;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic rdy;
    int   base, fd_base;

    vecs[0]  = '{OP_JUMP, 12'd1,   12'd2,   1'b1};
    vecs[1]  = '{OP_DRAW, 12'd3,   12'd4,   1'b1};
    vecs[2]  = '{OP_DRAW, 12'd5,   12'd6,   1'b1};
    vecs[3]  = '{OP_JUMP, 12'd7,   12'd8,   1'b1};
    vecs[4]  = '{OP_DRAW, 12'd9,   12'd10,  1'b1};
    vecs[5]  = '{OP_DRAW, 12'd11,  12'd12,  1'b1};
    vecs[6]  = '{OP_JUMP, 12'hFFF, 12'h000, 1'b1};
    vecs[7]  = '{OP_DRAW, 12'h000, 12'hFFF, 1'b1};
    vecs[8]  = '{OP_DRAW, 12'h123, 12'h456, 1'b1};
    vecs[9]  = '{OP_JUMP, 12'h789, 12'hABC, 1'b1};
    vecs[10] = '{OP_DRAW, 12'hDEF, 12'h010, 1'b1};
    vecs[11] = '{OP_DRAW, 12'd20,  12'd21,  1'b1};
    vecs[12] = '{OP_JUMP, 12'd22,  12'd23,  1'b1};
    vecs[13] = '{OP_DRAW, 12'd24,  12'd25,  1'b1};
    vecs[14] = '{OP_JUMP, 12'd26,  12'd27,  1'b1};
    vecs[15] = '{OP_DRAW, 12'd28,  12'd29,  1'b1};
    vecs[16] = '{OP_DRAW, 12'd99,  12'd99,  1'b0};

    // Reset state
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(1);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_draw", draw, 0);
    check("rst_jump", jump, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // JUMP then DRAW against a drawer busy for 5 cycles
    enable    = 1'b1;
    drawer_on = 1;
    low_len   = 5;
    base      = p_kind.size();
    push(OP_JUMP, 12'd10, 12'd15, rdy);
    push(OP_DRAW, 12'd20, 12'd30, rdy);
    wait_pulses("a_pulses", base + 2, 100);
    if (p_kind.size() >= base + 2) begin
      check("a_jump_kind", p_kind[base], OP_JUMP);
      check("a_jump_x", p_x[base], 10);
      check("a_jump_y", p_y[base], 15);
      check("a_draw_kind", p_kind[base+1], OP_DRAW);
      check("a_draw_x", p_x[base+1], 20);
      check("a_draw_y", p_y[base+1], 30);
      // done edge + 8 settle cycles + IDLE pop cycle
      check("a_settle_gap", p_cyc[base+1] - rise_cyc, 10);
    end
    idle(30);
    check("a_busy_end", busy, 0);
    drawer_off();

    // DRAW with ready stuck high: 4-cycle ack timeout, then next command issues
    base = p_kind.size();
    push(OP_DRAW, 12'd100, 12'd200, rdy);
    push(OP_DRAW, 12'd300, 12'd400, rdy);
    wait_pulses("b_pulses", base + 2, 60);
    if (p_kind.size() >= base + 2) begin
      check("b_first_x", p_x[base], 100);
      check("b_second_kind", p_kind[base+1], OP_DRAW);
      check("b_second_y", p_y[base+1], 400);
      // ISSUE -> 4 WAIT_ACK cycles -> IDLE pop -> ISSUE
      check("b_timeout_gap", p_cyc[base+1] - p_cyc[base], 6);
    end
    idle(10);

    // Fill 17 entries with enable low, then drain in order
    enable = 1'b0;
    base   = p_kind.size();
    for (int i = 0; i < 17; i++) begin
      push(vecs[i].op, vecs[i].x, vecs[i].y, rdy);
      check($sformatf("c_ready_%0d", i), rdy, vecs[i].exp_ready);
    end
    idle(5);
    check("c_no_pulse_disabled", p_kind.size(), base);
    check("c_busy_disabled", busy, 0);
    enable = 1'b1;
    wait_pulses("c_drain", base + 16, 600);
    idle(20);
    check("c_dropped_17th", p_kind.size(), base + 16);
    for (int i = 0; i < 16; i++) begin
      if (p_kind.size() > base + i) begin
        check($sformatf("c_kind_%0d", i), p_kind[base+i], vecs[i].op);
        check($sformatf("c_x_%0d", i), p_x[base+i], vecs[i].x);
        check($sformatf("c_y_%0d", i), p_y[base+i], vecs[i].y);
      end
    end
    check("c_ready_after", cmd_ready, 1);

    // NOP and three frames from a zero count
    base    = p_kind.size();
    fd_base = fd_count;
    push(OP_NOP, 12'd0, 12'd0, rdy);
    push(OP_END, 12'd0, 12'd0, rdy);
    push(OP_END, 12'd0, 12'd0, rdy);
    push(OP_END, 12'd0, 12'd0, rdy);
    idle(15);
    check("f_count", frame_count, 16'd3);
    check("f_done_pulses", fd_count - fd_base, 3);
    check("f_no_draw", p_kind.size(), base);

    // Wrap: count preloaded near the top, then real frames
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.frame_count_q;
    push(OP_END, 12'd0, 12'd0, rdy);
    push(OP_END, 12'd0, 12'd0, rdy);
    idle(10);
    check("w_count_ffff", frame_count, 16'hFFFF);
    fd_base = fd_count;
    push(OP_END, 12'd0, 12'd0, rdy);
    idle(10);
    check("w_done_pulse", fd_count - fd_base, 1);
    check("w_count_wrap", frame_count, 16'h0000);

    // Reset while waiting for the drawer to finish
    drawer_on = 1;
    low_len   = 20;
    base      = p_kind.size();
    push(OP_DRAW, 12'd7, 12'd9, rdy);
    push(OP_JUMP, 12'd1, 12'd2, rdy);
    wait_pulses("r_pulse", base + 1, 40);
    idle(4);
    check("r_busy_before", busy, 1);
    reset = 1'b0;
    idle(1);
    check("r_x", x, 0);
    check("r_y", y, 0);
    check("r_busy", busy, 0);
    check("r_cmd_ready", cmd_ready, 1);
    check("r_frame_count", frame_count, 0);
    reset = 1'b1;
    drawer_off();
    idle(40);
    check("r_no_more_pulses", p_kind.size(), base + 1);
    check("r_no_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
